// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable data width, parity, stop bits and baud divisor,
// with a ready/valid accept handshake and back-to-back frame support.
module uart_tx_param #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] i_tx_d,
    input  logic                 i_tx_en,
    output logic                 o_tx_ready,
    output logic                 o_tx_complete,
    output logic                 o_tx_d
);

    localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD;
    localparam int unsigned TW        = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (BIT_TICKS < 2) begin : g_bad_bit_ticks
        $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 wrap;

    always_comb begin
        wrap    = (tick_q == TICK_LAST);
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        if (state_q != StIdle) begin
            tick_d = wrap ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (i_tx_en && ready_q) begin
                    shift_d = i_tx_d;
                    par_d   = (PARITY == 1) ? ~^i_tx_d : ^i_tx_d;
                    tick_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (wrap) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (wrap) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = StParity;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        // Bit 0 is already on the line, so the next bit is shift_q[1].
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (wrap) begin
                    bit_d   = '0;
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (wrap) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign o_tx_d        = tx_q;
    assign o_tx_ready    = ready_q;
    assign o_tx_complete = done_q;

endmodule
